tcm_port_arbiter: RTL and testbench

- Shares one port of the dual-port TCM RAM between two requesters: requester 0 is the core data bus, requester 1 is the DMA/boot loader.
- Accepts at most one request per cycle and drives the RAM port combinationally.
- Tags each issued access and routes the RAM's 1-cycle read data back to the owner.
- Supports a lock for uninterrupted requester-1 bursts, bounded by a lock-length counter.

---
 rtl/tcm_port_arbiter_if.sv | 46 ++++
 rtl/tcm_port_arbiter.sv | 127 ++++++++++++
 tb/tb_tcm_port_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tcm_port_arbiter_if.sv
// Bundle of requester, response and RAM-port signals for the TCM port
// arbiter. The slave modport is the arbiter; the master modport is the
// surrounding system (both requesters and the RAM read-data return).
interface tcm_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req0_valid_i;
  logic [ADDR_WIDTH-1:0] req0_addr_i;
  logic [31:0]           req0_data_i;
  logic [3:0]            req0_wr_i;
  logic                  req0_ready_o;
  logic                  rsp0_valid_o;
  logic [31:0]           rsp0_data_o;

  logic                  req1_valid_i;
  logic [ADDR_WIDTH-1:0] req1_addr_i;
  logic [31:0]           req1_data_i;
  logic [3:0]            req1_wr_i;
  logic                  req1_lock_i;
  logic                  req1_ready_o;
  logic                  rsp1_valid_o;
  logic [31:0]           rsp1_data_o;

  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [31:0]           ram_data_o;
  logic [3:0]            ram_wr_o;
  logic [31:0]           ram_data_i;

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i, req0_wr_i,
    output req0_ready_o, rsp0_valid_o, rsp0_data_o,
    input  req1_valid_i, req1_addr_i, req1_data_i, req1_wr_i, req1_lock_i,
    output req1_ready_o, rsp1_valid_o, rsp1_data_o,
    output ram_addr_o, ram_data_o, ram_wr_o,
    input  ram_data_i
  );

  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i, req0_wr_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_data_o,
    output req1_valid_i, req1_addr_i, req1_data_i, req1_wr_i, req1_lock_i,
    input  req1_ready_o, rsp1_valid_o, rsp1_data_o,
    input  ram_addr_o, ram_data_o, ram_wr_o,
    output ram_data_i
  );
endinterface

// File: rtl/tcm_port_arbiter.sv
// Two-requester arbiter for one TCM RAM port. Requester 0 is the core data
// bus, requester 1 the DMA/boot loader. One access per cycle drives the RAM
// port combinationally; the 1-cycle read data returns to the owner tagged by
// a single pending-response register. Requester 1 may lock the port for
// bursts of up to MAX_LOCK grants, after which requester 0 gets one
// guaranteed contended win.
// Build option: define TCM_ARB_RR_EN for round-robin on contended unlocked
// cycles; otherwise requester 0 has fixed priority.
module tcm_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_LOCK   = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  tcm_port_arbiter_if.slave bus
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  lock_state_e lock_q;
  logic [7:0]  lock_cnt_q;
  logic        pend_valid_q;
  logic        pend_id_q;
  logic        last_grant_q;
  logic        starve_q;

  logic gnt0, gnt1, pick1, contended;
  logic unused_addr_bits;

  // Word addressing drops the byte offset bits.
  assign unused_addr_bits = ^{bus.req0_addr_i[1:0], bus.req1_addr_i[1:0]};

  // Grant decision: lock first, then single requester, then contention policy.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
`ifdef TCM_ARB_RR_EN
    pick1     = (last_grant_q == 1'b0);
`else
    pick1     = 1'b0;
`endif
    if (starve_q) pick1 = 1'b0;
    contended = !rst_i && bus.req0_valid_i && bus.req1_valid_i && (lock_q == UNLOCKED);
    if (!rst_i) begin
      if ((lock_q == LOCKED) && bus.req1_valid_i) begin
        gnt1 = 1'b1;
      end else if (bus.req0_valid_i && bus.req1_valid_i) begin
        gnt1 = pick1;
        gnt0 = !pick1;
      end else begin
        gnt0 = bus.req0_valid_i;
        gnt1 = bus.req1_valid_i;
      end
    end
  end

  // RAM port mux and response routing; idle port drives zeros.
  always_comb begin
    bus.req0_ready_o = gnt0;
    bus.req1_ready_o = gnt1;
    bus.ram_addr_o   = '0;
    bus.ram_data_o   = '0;
    bus.ram_wr_o     = '0;
    if (gnt0) begin
      bus.ram_addr_o = {2'b00, bus.req0_addr_i[ADDR_WIDTH-1:2]};
      bus.ram_data_o = bus.req0_data_i;
      bus.ram_wr_o   = bus.req0_wr_i;
    end else if (gnt1) begin
      bus.ram_addr_o = {2'b00, bus.req1_addr_i[ADDR_WIDTH-1:2]};
      bus.ram_data_o = bus.req1_data_i;
      bus.ram_wr_o   = bus.req1_wr_i;
    end
    bus.rsp0_valid_o = !rst_i && pend_valid_q && (pend_id_q == 1'b0);
    bus.rsp1_valid_o = !rst_i && pend_valid_q && (pend_id_q == 1'b1);
    bus.rsp0_data_o  = bus.ram_data_i;
    bus.rsp1_data_o  = bus.ram_data_i;
  end

  // Response tag, grant history and lock FSM with its length counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      lock_q       <= UNLOCKED;
      lock_cnt_q   <= 8'd0;
      starve_q     <= 1'b0;
    end else begin
      pend_valid_q <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        pend_id_q    <= gnt1;
        last_grant_q <= gnt1;
      end
      // The anti-starvation win is consumed by the first contended cycle.
      if (contended) starve_q <= 1'b0;
      case (lock_q)
        UNLOCKED: begin
          if (gnt1 && bus.req1_lock_i) begin
            if (MAX_LOCK <= 1) begin
              // A one-grant burst is already exhausted on entry.
              starve_q <= 1'b1;
            end else begin
              lock_q     <= LOCKED;
              lock_cnt_q <= 8'd1;
            end
          end
        end
        LOCKED: begin
          if (!bus.req1_valid_i || !bus.req1_lock_i) begin
            lock_q     <= UNLOCKED;
            lock_cnt_q <= 8'd0;
          end else if (lock_cnt_q == MAX_LOCK_C - 8'd1) begin
            lock_q     <= UNLOCKED;
            lock_cnt_q <= 8'd0;
            starve_q   <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
          end
        end
        default: lock_q <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter with a read-first RAM model and a
// scoreboard of expected responses (id + read data) filled at acceptance.
module tb_tcm_port_arbiter;
  localparam int AW = 16;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcm_port_arbiter_if #(.ADDR_WIDTH(AW)) bus();

  tcm_port_arbiter #(.ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // RAM contents are stored as XOR against the initial pattern.
  bit [31:0] ram_mem [0:16383];
  bit [31:0] ref_mem [0:16383];

  // Read-first RAM model, 1-cycle read latency.
  always @(posedge clk) begin : ram_model
    int a;
    logic [31:0] w;
    a = int'(bus.ram_addr_o[13:0]);
    w = ram_mem[a] ^ init_word(a);
    bus.ram_data_i <= w;
    for (int b = 0; b < 4; b++)
      if (bus.ram_wr_o[b]) w[b*8 +: 8] = bus.ram_data_o[b*8 +: 8];
    if (bus.ram_wr_o != 4'd0) ram_mem[a] <= w ^ init_word(a);
  end

  typedef struct {
    logic        id;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(string tag);
    rsp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".rsp0_valid"}, 32'(bus.rsp0_valid_o), 32'(e.id == 1'b0));
      chk({tag, ".rsp1_valid"}, 32'(bus.rsp1_valid_o), 32'(e.id == 1'b1));
      if (e.id == 1'b0) chk({tag, ".rsp0_data"}, bus.rsp0_data_o, e.data);
      else              chk({tag, ".rsp1_data"}, bus.rsp1_data_o, e.data);
    end else begin
      chk({tag, ".rsp0_idle"}, 32'(bus.rsp0_valid_o), 32'd0);
      chk({tag, ".rsp1_idle"}, 32'(bus.rsp1_valid_o), 32'd0);
    end
  endtask

  // One cycle: check last cycle's response, drive requests, check grant and
  // RAM port, record the expected response. g: 0/1 = granted id, 2 = none.
  task automatic step(string tag,
                      logic v0, logic [15:0] a0, logic [31:0] d0, logic [3:0] w0,
                      logic v1, logic [15:0] a1, logic [31:0] d1, logic [3:0] w1,
                      logic l1, int g);
    logic [15:0] ea;
    logic [31:0] ed, old, nw;
    logic [3:0]  ew;
    int          wi;
    @(negedge clk);
    check_rsp(tag);
    rst = 1'b0;
    bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0; bus.req0_wr_i = w0;
    bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1; bus.req1_wr_i = w1;
    bus.req1_lock_i  = l1;
    #1;
    chk({tag, ".ready0"}, 32'(bus.req0_ready_o), 32'(g == 0));
    chk({tag, ".ready1"}, 32'(bus.req1_ready_o), 32'(g == 1));
    ea = 16'd0; ed = 32'd0; ew = 4'd0;
    if (g == 0) begin ea = {2'b00, a0[15:2]}; ed = d0; ew = w0; end
    if (g == 1) begin ea = {2'b00, a1[15:2]}; ed = d1; ew = w1; end
    chk({tag, ".ram_addr"}, 32'(bus.ram_addr_o), 32'(ea));
    chk({tag, ".ram_data"}, bus.ram_data_o, ed);
    chk({tag, ".ram_wr"},   32'(bus.ram_wr_o), 32'(ew));
    if (g != 2) begin
      wi  = int'(ea[13:0]);
      old = ref_mem[wi] ^ init_word(wi);
      sb.push_back('{id: (g == 1), data: old});
      nw = old;
      for (int b = 0; b < 4; b++) if (ew[b]) nw[b*8 +: 8] = ed[b*8 +: 8];
      ref_mem[wi] = nw ^ init_word(wi);
    end
  endtask

  task automatic idle(string tag);
    step(tag, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 2);
  endtask

  // Reset cycle with both requesters asserting; any in-flight response is dropped.
  task automatic reset_cycle(string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 16'h0044; bus.req0_wr_i = 4'hF;
    bus.req0_data_i  = 32'hDEADBEEF;
    bus.req1_valid_i = 1'b1; bus.req1_addr_i = 16'h0088; bus.req1_wr_i = 4'hF;
    bus.req1_data_i  = 32'hFEEDF00D; bus.req1_lock_i = 1'b1;
    sb.delete();
    #1;
    chk({tag, ".ready0"},   32'(bus.req0_ready_o), 32'd0);
    chk({tag, ".ready1"},   32'(bus.req1_ready_o), 32'd0);
    chk({tag, ".rsp0"},     32'(bus.rsp0_valid_o), 32'd0);
    chk({tag, ".rsp1"},     32'(bus.rsp1_valid_o), 32'd0);
    chk({tag, ".ram_wr"},   32'(bus.ram_wr_o), 32'd0);
    chk({tag, ".ram_addr"}, 32'(bus.ram_addr_o), 32'd0);
    chk({tag, ".ram_data"}, bus.ram_data_o, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int g_rr [4];
    rst = 1'b1;
    bus.req0_valid_i = 1'b0; bus.req0_addr_i = '0; bus.req0_data_i = '0; bus.req0_wr_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_addr_i = '0; bus.req1_data_i = '0; bus.req1_wr_i = '0;
    bus.req1_lock_i  = 1'b0;
    reset_cycle("rst_a");
    reset_cycle("rst_b");

    // Contention right after reset (last grant = 1).
`ifdef TCM_ARB_RR_EN
    g_rr = '{0, 1, 0, 1};
`else
    g_rr = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++)
      step("contend", 1'b1, 16'h0020 + 16'(i*4), 32'h0, 4'h0,
                      1'b1, 16'h0200 + 16'(i*4), 32'h0, 4'h0, 1'b0, g_rr[i]);
    idle("idle0");

    // Single read, byte write, read-back, full write and back-to-back reads.
    step("rd0",   1'b1, 16'h0010, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 0);
    idle("idle1");
    step("bwr1",  1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0100, 32'h0000AB00, 4'b0010, 1'b0, 1);
    step("rdbk0", 1'b1, 16'h0100, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 0);
    step("wr1",   1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0300, 32'h12345678, 4'hF, 1'b0, 1);
    step("rd1",   1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0300, 32'h0, 4'h0, 1'b0, 1);
    step("rd0b",  1'b1, 16'h0302, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 0);
    idle("idle2");

    // Lock burst bounded at MAX_LOCK, then one anti-starvation win for req0.
    step("lk_s",  1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0400, 32'h0, 4'h0, 1'b1, 1);
    for (int i = 0; i < 3; i++)
      step("lk_b", 1'b1, 16'h0040, 32'h0, 4'h0, 1'b1, 16'h0404 + 16'(i*4), 32'h0, 4'h0, 1'b1, 1);
    step("lk_st", 1'b1, 16'h0040, 32'h0, 4'h0, 1'b1, 16'h0410, 32'h0, 4'h0, 1'b1, 0);
    step("lk_rs", 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0410, 32'h0, 4'h0, 1'b1, 1);
    step("lk_end",1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0414, 32'h0, 4'h0, 1'b0, 1);
    idle("idle3");

    // Lock released by req1 dropping valid; next contention uses the policy.
    step("rl_s",  1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0500, 32'h0, 4'h0, 1'b1, 1);
    step("rl_b",  1'b1, 16'h0050, 32'h0, 4'h0, 1'b1, 16'h0504, 32'h0, 4'h0, 1'b1, 1);
    step("rl_gap",1'b1, 16'h0050, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 0);
`ifdef TCM_ARB_RR_EN
    step("rl_pol",1'b1, 16'h0054, 32'h0, 4'h0, 1'b1, 16'h0508, 32'h0, 4'h0, 1'b1, 1);
`else
    step("rl_pol",1'b1, 16'h0054, 32'h0, 4'h0, 1'b1, 16'h0508, 32'h0, 4'h0, 1'b1, 0);
`endif
    idle("idle4");

    // Reset right after an accepted read drops its response.
    step("mr_rd", 1'b1, 16'h0060, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 0);
    reset_cycle("mr_rst");
    idle("mr_i0");
    idle("mr_i1");

    // Reset clears an active lock.
    step("ml_s",  1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0600, 32'h0, 4'h0, 1'b1, 1);
    reset_cycle("ml_rst");
    step("ml_c",  1'b1, 16'h0070, 32'h0, 4'h0, 1'b1, 16'h0604, 32'h0, 4'h0, 1'b1, 0);
    idle("final");
    idle("final2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
